mcb_host_if: RTL and testbench

- Front-end initiator for the MCB command/data interface; the other end of the back-end controller.
- Accepts single user transactions (address, direction, burst length) and buffers write data.
- Issues the mcb_bb request when the back-end is not busy, supplies write beats on mcb_wdat_req and collects read beats on mcb_rdat_vld.
- Sits between the system-bus adapter and the MCB back-end.

---
 rtl/mcb_host_if_if.sv | 45 ++++
 rtl/mcb_host_if.sv | 117 +++++++++++
 tb/tb_mcb_host_if.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mcb_host_if_if.sv
// Bundle of user-side and MCB-side signals for mcb_host_if.
// master = the host-if block itself, slave = the system-bus adapter / back-end side.
interface mcb_host_if_if #(
  parameter int AW = 22,
  parameter int DW = 16
);
  logic          usr_req;
  logic          usr_wr;
  logic [AW-1:0] usr_addr;
  logic [1:0]    usr_bl;
  logic          usr_ack;
  logic [DW-1:0] usr_wdat;
  logic          usr_wdat_vld;
  logic          usr_wdat_rdy;
  logic [DW-1:0] usr_rdat;
  logic          usr_rdat_vld;
  logic          usr_done;
  logic          usr_err;
  logic          usr_err_clr;
  logic          mcb_bb;
  logic          mcb_wr_n;
  logic [1:0]    mcb_bl;
  logic [AW-1:0] mcb_addr;
  logic          mcb_busy;
  logic          mcb_wdat_req;
  logic [DW-1:0] mcb_wdat;
  logic          mcb_rdat_vld;
  logic [DW-1:0] mcb_rdat;

  // Handshakes: usr_req is held until the usr_ack pulse; a write word moves on a cycle
  // with usr_wdat_vld && usr_wdat_rdy; mcb_bb, usr_done and usr_rdat_vld are one-cycle pulses.
  modport master (
    input  usr_req, usr_wr, usr_addr, usr_bl, usr_wdat, usr_wdat_vld, usr_err_clr,
    input  mcb_busy, mcb_wdat_req, mcb_rdat_vld, mcb_rdat,
    output usr_ack, usr_wdat_rdy, usr_rdat, usr_rdat_vld, usr_done, usr_err,
    output mcb_bb, mcb_wr_n, mcb_bl, mcb_addr, mcb_wdat
  );

  modport slave (
    output usr_req, usr_wr, usr_addr, usr_bl, usr_wdat, usr_wdat_vld, usr_err_clr,
    output mcb_busy, mcb_wdat_req, mcb_rdat_vld, mcb_rdat,
    input  usr_ack, usr_wdat_rdy, usr_rdat, usr_rdat_vld, usr_done, usr_err,
    input  mcb_bb, mcb_wr_n, mcb_bl, mcb_addr, mcb_wdat
  );
endinterface

// File: rtl/mcb_host_if.sv
// MCB front-end initiator: captures one user transaction, buffers write data, issues the
// command and moves beats. Optional beat watchdog enabled by defining MCB_HOST_TIMEOUT_EN.
module mcb_host_if #(
  parameter int AW     = 22,
  parameter int DW     = 16,
  parameter int TO_CYC = 255
) (
  input  logic          mcb_clk,
  input  logic          mcb_rst,
  mcb_host_if_if.master bus,
  output logic [2:0]    dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WFILL = 3'd1,
    S_ISSUE = 3'd2,
    S_WDATA = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    fill_cnt, beat_cnt, n_beats;
  logic [DW-1:0] wbuf [8];
  logic          capture, wr_fire, wbeat, rbeat, proto_err, timeout;

  assign n_beats   = 4'd1 << bus.mcb_bl;
  assign capture   = (state == S_IDLE) && bus.usr_req;
  assign wr_fire   = bus.usr_wdat_vld && bus.usr_wdat_rdy;
  assign wbeat     = (state == S_WDATA) && bus.mcb_wdat_req;
  assign rbeat     = (state == S_RDATA) && bus.mcb_rdat_vld;
  // Beats arriving in any other state are dropped and flagged.
  assign proto_err = (bus.mcb_wdat_req && (state != S_WDATA)) ||
                     (bus.mcb_rdat_vld && (state != S_RDATA));
  assign dbg_state = state;

`ifdef MCB_HOST_TIMEOUT_EN
  logic [7:0] wd_cnt;

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst || ((state != S_WDATA) && (state != S_RDATA)) || wbeat || rbeat)
      wd_cnt <= 8'd0;
    else if (wd_cnt != 8'hFF)
      wd_cnt <= wd_cnt + 8'd1;
  end

  assign timeout = ((state == S_WDATA) || (state == S_RDATA)) && !wbeat && !rbeat &&
                   (wd_cnt == 8'(TO_CYC));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.usr_req) state_nxt = bus.usr_wr ? S_WFILL : S_ISSUE;
      S_WFILL: if (wr_fire && ((fill_cnt + 4'd1) == n_beats)) state_nxt = S_ISSUE;
      S_ISSUE: if (!bus.mcb_busy) state_nxt = bus.mcb_wr_n ? S_RDATA : S_WDATA;
      S_WDATA: if ((wbeat && ((beat_cnt + 4'd1) == n_beats)) || timeout) state_nxt = S_DONE;
      S_RDATA: if ((rbeat && ((beat_cnt + 4'd1) == n_beats)) || timeout) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.usr_wdat_rdy = (state == S_WFILL) && (fill_cnt < n_beats);
    bus.mcb_bb       = (state == S_ISSUE) && !bus.mcb_busy;
    bus.usr_done     = (state == S_DONE);
  end

  always_ff @(posedge mcb_clk) begin
    if (wr_fire) wbuf[fill_cnt[2:0]] <= bus.usr_wdat;
  end

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst) begin
      bus.usr_ack      <= 1'b0;
      bus.mcb_wr_n     <= 1'b1;
      bus.mcb_bl       <= 2'd0;
      bus.mcb_addr     <= '0;
      bus.mcb_wdat     <= '0;
      bus.usr_rdat     <= '0;
      bus.usr_rdat_vld <= 1'b0;
      bus.usr_err      <= 1'b0;
      fill_cnt         <= 4'd0;
      beat_cnt         <= 4'd0;
    end else begin
      bus.usr_ack      <= capture;
      bus.usr_rdat_vld <= rbeat;
      if (capture) begin
        bus.mcb_wr_n <= ~bus.usr_wr;
        bus.mcb_addr <= bus.usr_addr;
        bus.mcb_bl   <= bus.usr_bl;
        fill_cnt     <= 4'd0;
        beat_cnt     <= 4'd0;
      end
      if (wr_fire) fill_cnt <= fill_cnt + 4'd1;
      if (wbeat) begin
        bus.mcb_wdat <= wbuf[beat_cnt[2:0]];
        beat_cnt     <= beat_cnt + 4'd1;
      end
      if (rbeat) begin
        bus.usr_rdat <= bus.mcb_rdat;
        beat_cnt     <= beat_cnt + 4'd1;
      end
      // A new error in the clearing cycle keeps the flag set.
      if (proto_err || timeout) bus.usr_err <= 1'b1;
      else if (bus.usr_err_clr) bus.usr_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mcb_host_if.sv
// Directed bench for mcb_host_if: write, read, busy stall, protocol errors, reset abort.
module tb_mcb_host_if;
  localparam int AW = 22;
  localparam int DW = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  int         tests = 0;
  int         fails = 0;
  int         bb_pulses = 0;

  mcb_host_if_if #(.AW(AW), .DW(DW)) bus ();

  mcb_host_if #(.AW(AW), .DW(DW), .TO_CYC(16)) dut (
    .mcb_clk   (clk),
    .mcb_rst   (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mcb_bb === 1'b1) bb_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [DW-1:0] rd_exp [8];
    bit            seen;
    int            gap;
    rst = 1'b1;
    bus.usr_req = 0; bus.usr_wr = 0; bus.usr_addr = '0; bus.usr_bl = 0;
    bus.usr_wdat = '0; bus.usr_wdat_vld = 0; bus.usr_err_clr = 0;
    bus.mcb_busy = 0; bus.mcb_wdat_req = 0; bus.mcb_rdat_vld = 0; bus.mcb_rdat = '0;
    tick(); tick();
    chk("rst_bb", bus.mcb_bb, 0);
    chk("rst_wr_n", bus.mcb_wr_n, 1);
    chk("rst_ack", bus.usr_ack, 0);
    chk("rst_done", bus.usr_done, 0);
    chk("rst_err", bus.usr_err, 0);
    chk("rst_wrdy", bus.usr_wdat_rdy, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick();

    // Write burst of 4 words.
    bus.usr_req = 1; bus.usr_wr = 1; bus.usr_addr = 22'h00100; bus.usr_bl = 2'b10;
    tick();
    chk("w_ack", bus.usr_ack, 1);
    chk("w_wr_n", bus.mcb_wr_n, 0);
    chk("w_addr", bus.mcb_addr, 32'h00100);
    chk("w_bl", bus.mcb_bl, 2);
    chk("w_rdy", bus.usr_wdat_rdy, 1);
    bus.usr_req = 0;
    for (int i = 0; i < 4; i++) begin
      bus.usr_wdat = 16'hA000 + 16'(i); bus.usr_wdat_vld = 1;
      tick();
      if (i == 0) chk("w_ack_pulse", bus.usr_ack, 0);
    end
    bus.usr_wdat_vld = 0;
    chk("w_issue_bb", bus.mcb_bb, 1);
    chk("w_rdy_full", bus.usr_wdat_rdy, 0);
    tick();
    chk("w_bb_once", bus.mcb_bb, 0);
    chk("w_state_wdata", dbg_state, 3);
    bus.mcb_wdat_req = 1; tick();
    chk("w_beat0", bus.mcb_wdat, 16'hA000);
    bus.mcb_wdat_req = 0; tick();
    chk("w_hold0", bus.mcb_wdat, 16'hA000);
    bus.mcb_wdat_req = 1; tick();
    chk("w_beat1", bus.mcb_wdat, 16'hA001);
    bus.mcb_wdat_req = 0; tick(); tick(); tick();
    bus.mcb_wdat_req = 1; tick();
    chk("w_beat2", bus.mcb_wdat, 16'hA002);
    chk("w_nodone", bus.usr_done, 0);
    tick();
    chk("w_beat3", bus.mcb_wdat, 16'hA003);
    chk("w_done", bus.usr_done, 1);
    bus.mcb_wdat_req = 0; tick();
    chk("w_done_pulse", bus.usr_done, 0);
    chk("w_idle", dbg_state, 0);
    chk("w_noerr", bus.usr_err, 0);

    // Read burst of 8 beats with random gaps.
    bus.usr_req = 1; bus.usr_wr = 0; bus.usr_addr = 22'h3A5A5; bus.usr_bl = 2'b11;
    tick();
    chk("r_ack", bus.usr_ack, 1);
    chk("r_wr_n", bus.mcb_wr_n, 1);
    chk("r_addr", bus.mcb_addr, 32'h3A5A5);
    chk("r_bb", bus.mcb_bb, 1);
    bus.usr_req = 0;
    tick();
    chk("r_state_rdata", dbg_state, 4);
    for (int i = 0; i < 8; i++) begin
      rd_exp[i] = 16'hD000 + 16'(i * 16'h0111);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("r_gap_vld", bus.usr_rdat_vld, 0);
      end
      bus.mcb_rdat = rd_exp[i]; bus.mcb_rdat_vld = 1;
      tick();
      bus.mcb_rdat_vld = 0; bus.mcb_rdat = 16'hFFFF;
      chk("r_vld", bus.usr_rdat_vld, 1);
      chk("r_data", bus.usr_rdat, rd_exp[i]);
      chk("r_done_at_beat", bus.usr_done, (i == 7) ? 1 : 0);
    end
    tick();
    chk("r_idle", dbg_state, 0);

    // Read stalled by busy.
    bus.mcb_busy = 1;
    bus.usr_req = 1; bus.usr_wr = 0; bus.usr_addr = 22'h00042; bus.usr_bl = 2'b00;
    tick();
    bus.usr_req = 0;
    bb_pulses = 0;
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      if (bus.mcb_bb !== 1'b0) seen = 1;
      tick();
    end
    chk("b_bb_held_low", seen, 0);
    chk("b_state_issue", dbg_state, 2);
    bus.mcb_busy = 0; #1;
    chk("b_bb_on_drop", bus.mcb_bb, 1);
    tick();
    chk("b_bb_after", bus.mcb_bb, 0);
    bus.mcb_rdat = 16'hBEEF; bus.mcb_rdat_vld = 1; tick();
    bus.mcb_rdat_vld = 0;
    chk("b_rdat", bus.usr_rdat, 16'hBEEF);
    chk("b_done", bus.usr_done, 1);
    tick();
    chk("b_bb_count", bb_pulses, 1);

    // Protocol errors in IDLE, sticky flag and clear priority.
    bus.mcb_rdat = 16'h1234; bus.mcb_rdat_vld = 1; tick();
    bus.mcb_rdat_vld = 0;
    chk("e_no_vld", bus.usr_rdat_vld, 0);
    chk("e_err_set", bus.usr_err, 1);
    chk("e_rdat_kept", bus.usr_rdat, 16'hBEEF);
    tick();
    chk("e_sticky", bus.usr_err, 1);
    bus.usr_err_clr = 1; tick();
    chk("e_clear", bus.usr_err, 0);
    bus.mcb_wdat_req = 1; tick();
    bus.mcb_wdat_req = 0;
    chk("e_set_wins", bus.usr_err, 1);
    chk("e_wdat_kept", bus.mcb_wdat, 16'hA003);
    tick();
    bus.usr_err_clr = 0;
    chk("e_clear2", bus.usr_err, 0);

    // Reset in the middle of a write fill.
    bus.usr_req = 1; bus.usr_wr = 1; bus.usr_addr = 22'h00777; bus.usr_bl = 2'b01;
    tick();
    bus.usr_req = 0;
    bus.usr_wdat = 16'h5555; bus.usr_wdat_vld = 1; tick();
    bus.usr_wdat_vld = 0;
    chk("m_state_wfill", dbg_state, 1);
    rst = 1; tick();
    rst = 0;
    chk("m_state_idle", dbg_state, 0);
    chk("m_wr_n", bus.mcb_wr_n, 1);
    chk("m_rdy", bus.usr_wdat_rdy, 0);
    chk("m_done", bus.usr_done, 0);
    chk("m_addr", bus.mcb_addr, 0);
    tick();

`ifdef MCB_HOST_TIMEOUT_EN
    bus.usr_req = 1; bus.usr_wr = 0; bus.usr_addr = 22'h00010; bus.usr_bl = 2'b01;
    tick();
    bus.usr_req = 0;
    tick();
    bus.mcb_rdat = 16'h0BEE; bus.mcb_rdat_vld = 1; tick();
    bus.mcb_rdat_vld = 0;
    chk("t_beat", bus.usr_rdat_vld, 1);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.usr_done === 1'b1) seen = 1;
    end
    chk("t_done_seen", seen, 1);
    chk("t_err", bus.usr_err, 1);
    tick();
    chk("t_idle", dbg_state, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
